data_unpacker: RTL and testbench
================================

DATA_UNPACKER -- requirements
Module: dataUnpacker

Interface
REQ-001 SHALL have parameter N, default 8, meaning lanes per vector.
REQ-002 SHALL have parameter M, default 2, meaning lanes per medium chunk; N%M==0 required, elaboration error otherwise.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning bits per lane.
REQ-004 SHALL have parameter PERSONAL_CONFIG_ID, default 0, meaning configId value addressing this block.
REQ-005 SHALL have parameter INITIAL_MODE, default 0, meaning mode register value after reset.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-008 tracing  input  1  1 = data path active; 0 = configuration window.
REQ-009 configId  input  8  configuration target select.
REQ-010 configData  input  8  configuration byte.
REQ-011 valid_in  input  1  packed vector present.
REQ-012 ready_in  output  1  block accepts vector this cycle.
REQ-013 vector_in  input  N x DATA_WIDTH  packed vector; lane 0 = oldest element.
REQ-014 valid_out  output  1  chunk present on vector_out.
REQ-015 ready_out  input  1  downstream accepts chunk.
REQ-016 vector_out  output  N x DATA_WIDTH  chunk in lanes [k-1:0], upper lanes zero.
REQ-017 last_out  output  1  qualifies final chunk of current vector.

Function
REQ-018 Mode register (2 bits): 0 = full (k=N), 1 = medium (k=M), 2 = single (k=1), 3 = discard.
REQ-019 While tracing=0 and configId==PERSONAL_CONFIG_ID, mode SHALL load configData[1:0] each cycle; otherwise unchanged.
REQ-020 Accept = valid_in & ready_in & tracing; on accept, vector and mode latch into holding register; index idx=0.
REQ-021 ready_in SHALL be 1 when buffer empty, or when the last chunk is transferring (valid_out & ready_out & last_out) this cycle; no bubble between vectors.
REQ-022 First chunk SHALL be valid the cycle after accept (latency 1).
REQ-023 Chunk c SHALL carry held lanes [c*k+k-1 : c*k] in vector_out[k-1:0]; idx advances by k per transfer (valid_out & ready_out).
REQ-024 last_out SHALL be 1 iff idx+k==N; buffer empties after its transfer unless a new accept occurs in the same cycle.
REQ-025 valid_out & !ready_out SHALL hold vector_out, last_out, valid_out stable.
REQ-026 Latched mode 3: vector accepted and dropped; no valid_out; ready_in stays 1.
REQ-027 Mode changes SHALL not affect an in-flight vector.
REQ-028 tracing=0 SHALL not flush; in-flight chunks continue draining; no new accepts.
REQ-029 idx width clog2(N)+1; no wrap beyond N.

Reset
REQ-030 reset_n=0 SHALL immediately force valid_out=0, last_out=0, vector_out=0, idx=0, buffer empty, mode=INITIAL_MODE; ready_in=1 after release; in-flight data discarded.

Structure
REQ-031 Shared package SHALL hold mode enum (MODE_N, MODE_M, MODE_1, MODE_DISCARD) and a chunk-select function shared with dataPacker.
REQ-032 No sub-module; single module with holding register, idx counter and chunk mux.

Verification (N=8, M=2, DATA_WIDTH=32)
REQ-033 Mode 0, vector {0..7} accepted at t, ready_out=1 -> t+1: vector_out={0..7}, valid_out=1, last_out=1; single cycle.
REQ-034 Mode 2, vector {10..17} -> 8 cycles, lane0=10..17, lanes1-7=0; last_out on 8th; ready_in 0 cycles 1-7, 1 on cycle 8.
REQ-035 Mode 1, two back-to-back vectors {0..7},{8..15} -> 8 consecutive valid cycles, pairs (0,1)..(14,15), last_out on cycles 4 and 8.
REQ-036 Mode 1, ready_out low 3 cycles during chunk (2,3) -> chunk (2,3) held 3 cycles, then (4,5) follows.
REQ-037 reset_n low during second chunk -> valid_out=0 same cycle; after release ready_in=1, no residual chunks.
REQ-038 tracing=0, configId=0, configData=1 -> next vector unpacked as M-chunks; configId=5 -> mode unchanged.

Source files
------------

// File: rtl/data_unpacker_pkg.sv
// Shared definitions for the data packer/unpacker pair: lane-grouping modes and chunk lane selection.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package data_unpacker_pkg;

  // Lane grouping per transfer; DISCARD drops whole vectors.
  typedef enum logic [1:0] {
    MODE_N       = 2'd0,
    MODE_M       = 2'd1,
    MODE_1       = 2'd2,
    MODE_DISCARD = 2'd3
  } mode_t;

  localparam int MODE_W = 2;

  // Lanes moved per chunk for a given mode (discard never reaches the chunk path).
  function automatic int lanes_for_mode(mode_t md, int n, int m);
    case (md)
      MODE_N:  return n;
      MODE_M:  return m;
      MODE_1:  return 1;
      default: return n;
    endcase
  endfunction

  // Source lane in the full vector that feeds output lane 'lane' of the chunk starting at 'base'.
  function automatic int chunk_src(int base, int lane);
    return base + lane;
  endfunction

endpackage

// File: rtl/data_unpacker.sv
// Splits a packed N-lane vector into chunks of k lanes (k = N, M or 1), oldest lanes first.
// Latency: first chunk valid one cycle after accept; one chunk per cycle while ready_out is high.
// Backpressure: stalled chunks hold stable; ready_in reopens on the last chunk's transfer (no bubble).
module data_unpacker
  import data_unpacker_pkg::*;
#(
  parameter int N                  = 8,
  parameter int M                  = 2,
  parameter int DATA_WIDTH         = 32,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter int INITIAL_MODE       = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      tracing,
  input  logic [7:0]                configId,
  input  logic [7:0]                configData,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [N*DATA_WIDTH-1:0]   vector_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [N*DATA_WIDTH-1:0]   vector_out,
  output logic                      last_out
);

  localparam int IDXW = $clog2(N) + 1;
  localparam int VW   = N * DATA_WIDTH;

  // Chunks must tile the vector exactly, otherwise the last chunk would straddle the end.
  if ((N % M) != 0) begin : g_bad_m
    $error("data_unpacker: N must be a multiple of M");
  end

  mode_t                mode_q;
  mode_t                hold_mode;
  logic                 buf_vld;
  logic [VW-1:0]        hold_vec;
  logic [IDXW-1:0]      idx;
  logic [IDXW-1:0]      k_w;
  logic                 last_chunk;
  logic                 xfer;
  logic                 accept;
  logic                 unused_cfg;

  // Only the low bits of the config byte select a mode.
  assign unused_cfg = ^configData[7:2];

  // k comes from the mode captured with the vector, so later mode writes cannot disturb it.
  assign k_w        = IDXW'(lanes_for_mode(hold_mode, N, M));
  assign last_chunk = buf_vld && ((idx + k_w) == IDXW'(N));
  assign xfer       = buf_vld && ready_out;

  assign valid_out  = buf_vld;
  assign last_out   = last_chunk;
  assign ready_in   = !buf_vld || (xfer && last_chunk);
  assign accept     = valid_in && ready_in && tracing;

  // Mode register: written only during the configuration window by the matching config target.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= mode_t'(MODE_W'(INITIAL_MODE));
    end else if (!tracing && (configId == 8'(PERSONAL_CONFIG_ID))) begin
      mode_q <= mode_t'(configData[1:0]);
    end
  end

  // Holding register and lane index: load on accept, step by k per transfer, empty after the last chunk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld   <= 1'b0;
      hold_vec  <= '0;
      hold_mode <= MODE_N;
      idx       <= '0;
    end else if (accept) begin
      hold_vec  <= vector_in;
      hold_mode <= mode_q;
      idx       <= '0;
      buf_vld   <= (mode_q != MODE_DISCARD);
    end else if (xfer) begin
      if (last_chunk) begin
        buf_vld <= 1'b0;
        idx     <= '0;
      end else begin
        idx     <= idx + k_w;
      end
    end
  end

  // Chunk mux: lanes [k-1:0] carry held lanes starting at idx; upper lanes and empty buffer read zero.
  always_comb begin
    int src;
    vector_out = '0;
    src        = 0;
    for (int l = 0; l < N; l++) begin
      if (buf_vld && (l < int'(k_w))) begin
        src = chunk_src(int'(idx), l);
        if (src < N) begin
          vector_out[l*DATA_WIDTH +: DATA_WIDTH] = hold_vec[src*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker (N=8, M=2, DATA_WIDTH=32): cycle table plus a reset-in-flight sequence.
// Latency: inputs driven on the falling edge, outputs compared 1 ns later.
// Backpressure: exercised through ready_out patterns in the table.
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int DW = 32;

  logic              clk;
  logic              reset_n;
  logic              tracing;
  logic [7:0]        configId;
  logic [7:0]        configData;
  logic              valid_in;
  logic              ready_in;
  logic [N*DW-1:0]   vector_in;
  logic              valid_out;
  logic              ready_out;
  logic [N*DW-1:0]   vector_out;
  logic              last_out;

  int checks;
  int errors;

  data_unpacker #(
    .N(N), .M(M), .DATA_WIDTH(DW), .PERSONAL_CONFIG_ID(0), .INITIAL_MODE(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tracing(tracing),
    .configId(configId), .configData(configData),
    .valid_in(valid_in), .ready_in(ready_in), .vector_in(vector_in),
    .valid_out(valid_out), .ready_out(ready_out), .vector_out(vector_out),
    .last_out(last_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit vin;  int vb;   bit rout; bit trc; int cid; int cdat;
    bit erdy; bit evld; bit elast; int eb; int ek;
  } row_t;

  row_t tbl[$];

  // Lanes i<k hold base+i, the rest zero.
  function automatic logic [N*DW-1:0] mkvec(int base, int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  function automatic row_t r(bit vin, int vb, bit rout, bit trc, int cid, int cdat,
                             bit erdy, bit evld, bit elast, int eb, int ek);
    row_t x;
    x.vin = vin; x.vb = vb; x.rout = rout; x.trc = trc; x.cid = cid; x.cdat = cdat;
    x.erdy = erdy; x.evld = evld; x.elast = elast; x.eb = eb; x.ek = ek;
    return x;
  endfunction

  task automatic chk(input string nm, input int id, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic apply(input row_t x, input int id);
    logic [N*DW-1:0] ev;
    @(negedge clk);
    valid_in   = x.vin;
    vector_in  = mkvec(x.vb, N);
    ready_out  = x.rout;
    tracing    = x.trc;
    configId   = 8'(x.cid);
    configData = 8'(x.cdat);
    #1;
    ev = x.evld ? mkvec(x.eb, x.ek) : '0;
    chk("ready_in",   id, (N*DW)'(ready_in),  (N*DW)'(x.erdy));
    chk("valid_out",  id, (N*DW)'(valid_out), (N*DW)'(x.evld));
    chk("last_out",   id, (N*DW)'(last_out),  (N*DW)'(x.elast));
    chk("vector_out", id, vector_out, ev);
  endtask

  row_t idle;

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; tracing = 1'b1; configId = 8'd5; configData = 8'd0;
    valid_in = 1'b0; ready_out = 1'b1; vector_in = '0;
    idle = r(0,0,1,1,5,0, 1,0,0,0,0);

    // Full mode: whole vector in one chunk.
    tbl.push_back(idle);
    tbl.push_back(r(1,0,1,1,5,0,  1,0,0,0,0));
    tbl.push_back(r(0,0,1,1,5,0,  1,1,1,0,8));
    tbl.push_back(idle);
    // Single-lane mode: eight chunks, ready_in only on the last.
    tbl.push_back(r(0,0,1,0,0,2,  1,0,0,0,0));
    tbl.push_back(r(1,10,1,1,5,0, 1,0,0,0,0));
    for (int c = 0; c < 8; c++) tbl.push_back(r(0,0,1,1,5,0, c == 7, 1, c == 7, 10 + c, 1));
    tbl.push_back(idle);
    // Medium mode, foreign configId ignored, back-to-back vectors with no bubble.
    tbl.push_back(r(0,0,1,0,0,1,  1,0,0,0,0));
    tbl.push_back(r(0,0,1,0,5,3,  1,0,0,0,0));
    tbl.push_back(r(1,0,1,1,5,0,  1,0,0,0,0));
    for (int c = 0; c < 4; c++) tbl.push_back(r(1,8,1,1,5,0, c == 3, 1, c == 3, 2*c, 2));
    for (int c = 0; c < 4; c++) tbl.push_back(r(0,0,1,1,5,0, c == 3, 1, c == 3, 8 + 2*c, 2));
    tbl.push_back(idle);
    // Stall on chunk (2,3) for three cycles.
    tbl.push_back(r(1,0,1,1,5,0,  1,0,0,0,0));
    tbl.push_back(r(0,0,1,1,5,0,  0,1,0,0,2));
    for (int c = 0; c < 3; c++) tbl.push_back(r(0,0,0,1,5,0, 0,1,0,2,2));
    tbl.push_back(r(0,0,1,1,5,0,  0,1,0,2,2));
    tbl.push_back(r(0,0,1,1,5,0,  0,1,0,4,2));
    tbl.push_back(r(0,0,1,1,5,0,  1,1,1,6,2));
    tbl.push_back(idle);
    // Tracing drop: in-flight drains, pending vector is not taken.
    tbl.push_back(r(1,20,1,1,5,0, 1,0,0,0,0));
    for (int c = 0; c < 4; c++) tbl.push_back(r(1,40,1,0,5,0, c == 3, 1, c == 3, 20 + 2*c, 2));
    tbl.push_back(r(1,40,1,0,5,0, 1,0,0,0,0));
    tbl.push_back(idle);
    // Discard mode: vectors swallowed, ready_in stays high.
    tbl.push_back(r(0,0,1,0,0,3,  1,0,0,0,0));
    tbl.push_back(r(1,50,1,1,5,0, 1,0,0,0,0));
    tbl.push_back(r(1,60,1,1,5,0, 1,0,0,0,0));
    tbl.push_back(idle);
    // Mode rewrite while a medium vector drains does not change its chunking.
    tbl.push_back(r(0,0,1,0,0,1,  1,0,0,0,0));
    tbl.push_back(r(1,0,1,1,5,0,  1,0,0,0,0));
    tbl.push_back(r(0,0,1,0,0,0,  0,1,0,0,2));
    tbl.push_back(r(0,0,1,1,5,0,  0,1,0,2,2));
    tbl.push_back(r(0,0,1,1,5,0,  0,1,0,4,2));
    tbl.push_back(r(0,0,1,1,5,0,  1,1,1,6,2));
    tbl.push_back(idle);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_valid_out",  0, (N*DW)'(valid_out), '0);
    chk("rst_last_out",   0, (N*DW)'(last_out),  '0);
    chk("rst_vector_out", 0, vector_out,         '0);
    chk("rst_ready_in",   0, (N*DW)'(ready_in),  (N*DW)'(1));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset asserted while the second medium chunk is presented.
    apply(r(0,0,1,0,0,1, 1,0,0,0,0), 100);
    apply(r(1,0,1,1,5,0, 1,0,0,0,0), 101);
    apply(r(0,0,1,1,5,0, 0,1,0,0,2), 102);
    apply(r(0,0,1,1,5,0, 0,1,0,2,2), 103);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid_out",  104, (N*DW)'(valid_out), '0);
    chk("mid_rst_last_out",   104, (N*DW)'(last_out),  '0);
    chk("mid_rst_vector_out", 104, vector_out,         '0);
    chk("mid_rst_ready_in",   104, (N*DW)'(ready_in),  (N*DW)'(1));
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) apply(idle, 105 + i);
    // Mode returned to full after reset.
    apply(r(1,30,1,1,5,0, 1,0,0,0,0), 108);
    apply(r(0,0,1,1,5,0,  1,1,1,30,8), 109);
    apply(idle, 110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
